// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_types_pkg
//  Description : Shared CPU types. Holds the ALU operation encoding that the
//                control unit drives and the datapath ALU decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Interface   : multicycle_control_if
//  Description : Memory handshake between the multicycle control unit and
//                the instruction/data memories.
//  Ports       : iREN  - instruction read enable   (control -> memory)
//                dREN  - data read enable          (control -> memory)
//                dWEN  - data write enable         (control -> memory)
//                ihit  - instruction access done   (memory  -> control)
//                dhit  - data access done          (memory  -> control)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic iREN;
  logic dREN;
  logic dWEN;
  logic ihit;
  logic dhit;

  modport master (output iREN, output dREN, output dWEN,
                  input  ihit, input  dhit);
  modport slave  (input  iREN, input  dREN, input  dWEN,
                  output ihit, output dhit);
endinterface : multicycle_control_if
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Control FSM for a multicycle MIPS-subset CPU. Walks each
//                instruction through FETCH/DECODE/EXEC/MEM/WB, decodes all
//                datapath enables combinationally, bounds every memory wait
//                with a timeout, and counts retired instructions.
//  Ports       : CLK, nRST      - clock, asynchronous active-low reset
//                mem            - memory handshake (iREN/dREN/dWEN, ihit/dhit)
//                instruction    - instruction register contents
//                alu_zf         - ALU zero flag (branch resolution)
//                IRWr..ExtOp    - datapath enables
//                RegDst, MemToReg, ALUSrc, PCSrc, ALUctr - datapath selects
//                halt, mem_err  - stop indications
//                state          - current FSM state (debug)
//                retired        - retired-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  multicycle_control_if.master mem,
  input  logic [31:0]          instruction,
  input  logic                 alu_zf,
  output logic                 IRWr,
  output logic                 PCWr,
  output logic                 RegWr,
  output logic                 ExtOp,
  output logic [1:0]           RegDst,
  output logic [1:0]           MemToReg,
  output logic [1:0]           ALUSrc,
  output logic [2:0]           PCSrc,
  output aluop_t               ALUctr,
  output logic                 halt,
  output logic                 mem_err,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              iren, dren, dwen;

  // Instruction fields
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype, is_jr, is_lw, is_sw, is_branch;
  assign opcode    = instruction[31:26];
  assign funct     = instruction[5:0];
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_jr     = is_rtype && (funct == FN_JR);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instruction[25:6]};

  // Static ALU decode; only presented on the outputs in EXEC and WB.
  aluop_t     dec_alu;
  logic [1:0] dec_src;
  logic       dec_ext;
  logic       dec_valid;

  always_comb begin
    dec_alu   = ALU_ADD;
    dec_src   = 2'd0;
    dec_ext   = 1'b0;
    dec_valid = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'h00:   dec_alu = ALU_SLL;
          6'h02:   dec_alu = ALU_SRL;
          FN_JR:   dec_alu = ALU_ADD;
          6'h21:   dec_alu = ALU_ADD;
          6'h23:   dec_alu = ALU_SUB;
          6'h24:   dec_alu = ALU_AND;
          6'h25:   dec_alu = ALU_OR;
          6'h26:   dec_alu = ALU_XOR;
          6'h27:   dec_alu = ALU_NOR;
          6'h2A:   dec_alu = ALU_SLT;
          6'h2B:   dec_alu = ALU_SLTU;
          default: dec_valid = 1'b0;
        endcase
      end
      OP_J, OP_JAL: dec_valid = 1'b1;
      OP_BEQ, OP_BNE: begin
        dec_alu = ALU_SUB;
        dec_ext = 1'b1;
      end
      6'h09: begin dec_alu = ALU_ADD;  dec_src = 2'd1; dec_ext = 1'b1; end
      6'h0A: begin dec_alu = ALU_SLT;  dec_src = 2'd1; dec_ext = 1'b1; end
      6'h0B: begin dec_alu = ALU_SLTU; dec_src = 2'd1; dec_ext = 1'b1; end
      6'h0C: begin dec_alu = ALU_AND;  dec_src = 2'd1; end
      6'h0D: begin dec_alu = ALU_OR;   dec_src = 2'd1; end
      6'h0E: begin dec_alu = ALU_XOR;  dec_src = 2'd1; end
      6'h0F: begin dec_alu = ALU_OR;   dec_src = 2'd2; end
      OP_LW, OP_SW: begin
        dec_alu = ALU_ADD;
        dec_src = 2'd1;
        dec_ext = 1'b1;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    iren     = 1'b0;
    dren     = 1'b0;
    dwen     = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    RegWr    = 1'b0;
    ExtOp    = 1'b0;
    RegDst   = 2'd0;
    MemToReg = 2'd0;
    ALUSrc   = 2'd0;
    PCSrc    = 3'd0;
    ALUctr   = ALU_ADD;
    halt     = 1'b0;
    mem_err  = 1'b0;

    case (state_q)
      FETCH: begin
        iren = 1'b1;
        if (mem.ihit) begin
          IRWr    = 1'b1;
          state_d = DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERROR;
        end
      end

      DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = HALT;
        end else if (opcode == OP_J) begin
          PCWr    = 1'b1;
          PCSrc   = 3'd2;
          state_d = FETCH;
        end else if (opcode == OP_JAL) begin
          PCWr     = 1'b1;
          PCSrc    = 3'd2;
          RegWr    = 1'b1;
          RegDst   = 2'd2;
          MemToReg = 2'd2;
          state_d  = FETCH;
        end else if (!dec_valid) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        ALUctr = dec_alu;
        ALUSrc = dec_src;
        ExtOp  = dec_ext;
        if (is_branch) begin
          PCWr = 1'b1;
          // BEQ taken on zero, BNE taken on non-zero
          if ((opcode == OP_BEQ) == alu_zf) PCSrc = 3'd1;
          state_d = FETCH;
        end else if (is_jr) begin
          PCWr    = 1'b1;
          PCSrc   = 3'd3;
          state_d = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end

      MEM: begin
        dren = is_lw;
        dwen = !is_lw;
        if (mem.dhit) begin
          if (is_lw) begin
            state_d = WB;
          end else begin
            PCWr    = 1'b1;
            state_d = FETCH;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERROR;
        end
      end

      WB: begin
        ALUctr   = dec_alu;
        ALUSrc   = dec_src;
        ExtOp    = dec_ext;
        RegWr    = 1'b1;
        PCWr     = 1'b1;
        RegDst   = is_rtype ? 2'd1 : 2'd0;
        MemToReg = is_lw    ? 2'd1 : 2'd0;
        state_d  = FETCH;
      end

      HALT: halt = 1'b1;

      ERROR: begin
        halt    = 1'b1;
        mem_err = 1'b1;
      end

      default: state_d = FETCH;
    endcase
  end

  // The counter only runs while parked in FETCH or MEM; any transition
  // (including entry into those states) restarts it from zero.
  always_comb begin
    wait_cnt_d = 8'd0;
    if (((state_q == FETCH) || (state_q == MEM)) && (state_d == state_q))
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_comb begin
    retired_d = retired_q;
    if ((state_d == FETCH) && (state_q != FETCH))
      retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FETCH;
      wait_cnt_q <= 8'd0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  assign mem.iREN = iren;
  assign mem.dREN = dren;
  assign mem.dWEN = dwen;
  assign state    = state_q;
  assign retired  = retired_q;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A driver issues
//                one cycle of stimulus at a time and queues the hand-computed
//                expected outputs; a monitor on the falling edge pops each
//                entry and compares state, control vector, retired count and
//                (where relevant) the ALU controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
  import cpu_types_pkg::*;

  localparam int TO = 4;

  logic         CLK;
  logic         nRST;
  logic [31:0]  instruction;
  logic         alu_zf;
  logic         IRWr, PCWr, RegWr, ExtOp, halt, mem_err;
  logic [1:0]   RegDst, MemToReg, ALUSrc;
  logic [2:0]   PCSrc, state;
  aluop_t       ALUctr;
  logic [31:0]  retired;

  multicycle_control_if mif ();

  multicycle_control #(.TIMEOUT_CYC(TO), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .mem(mif), .instruction(instruction),
    .alu_zf(alu_zf), .IRWr(IRWr), .PCWr(PCWr), .RegWr(RegWr),
    .ExtOp(ExtOp), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
    .PCSrc(PCSrc), .ALUctr(ALUctr), .halt(halt), .mem_err(mem_err),
    .state(state), .retired(retired)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // States
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3,
                         S_W = 3'd4, S_H = 3'd5, S_X = 3'd6;

  // Control vector: {iREN,dREN,dWEN,IRWr,PCWr,RegWr,RegDst,MemToReg,PCSrc,halt,mem_err}
  localparam logic [14:0] C_ZERO    = {6'b000000, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_F_MISS  = {6'b100000, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_F_HIT   = {6'b100100, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_J       = {6'b000010, 2'd0, 2'd0, 3'd2, 2'b00};
  localparam logic [14:0] C_JAL     = {6'b000011, 2'd2, 2'd2, 3'd2, 2'b00};
  localparam logic [14:0] C_BR_T    = {6'b000010, 2'd0, 2'd0, 3'd1, 2'b00};
  localparam logic [14:0] C_BR_N    = {6'b000010, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_M_LW    = {6'b010000, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_M_SW    = {6'b001000, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_M_SWHIT = {6'b001010, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_WB_R    = {6'b000011, 2'd1, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_WB_LW   = {6'b000011, 2'd0, 2'd1, 3'd0, 2'b00};
  localparam logic [14:0] C_WB_I    = {6'b000011, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [14:0] C_HALT    = {6'b000000, 2'd0, 2'd0, 3'd0, 2'b10};
  localparam logic [14:0] C_ERR     = {6'b000000, 2'd0, 2'd0, 3'd0, 2'b11};

  // Instructions
  localparam logic [31:0] I_ADDU = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] I_LW   = {6'h23, 5'd1, 5'd2, 16'h0004};
  localparam logic [31:0] I_SW   = {6'h2B, 5'd1, 5'd2, 16'h0008};
  localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'hFFFC};
  localparam logic [31:0] I_BNE  = {6'h05, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_JAL  = {6'h03, 26'h0000040};
  localparam logic [31:0] I_J    = {6'h02, 26'h0000080};
  localparam logic [31:0] I_ORI  = {6'h0D, 5'd1, 5'd2, 16'h8001};
  localparam logic [31:0] I_LUI  = {6'h0F, 5'd0, 5'd2, 16'h1234};
  localparam logic [31:0] I_HALT = {6'h3F, 26'h0};
  localparam logic [31:0] I_BAD  = {6'h3E, 26'h0};

  typedef struct {
    logic [2:0]  st;
    logic [14:0] ctl;
    int unsigned ret;
    logic        chk_alu;
    aluop_t      alu;
    logic [1:0]  src;
    logic        ext;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compares whatever the DUT shows against the oldest expectation.
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (state !== mon_e.st) begin
        n_fail++;
        $display("FAIL %s state: got %0d want %0d", mon_e.nm, state, mon_e.st);
      end
      n_tests++;
      if ({mif.iREN, mif.dREN, mif.dWEN, IRWr, PCWr, RegWr, RegDst, MemToReg,
           PCSrc, halt, mem_err} !== mon_e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b want %b", mon_e.nm,
                 {mif.iREN, mif.dREN, mif.dWEN, IRWr, PCWr, RegWr, RegDst,
                  MemToReg, PCSrc, halt, mem_err}, mon_e.ctl);
      end
      n_tests++;
      if (retired !== mon_e.ret) begin
        n_fail++;
        $display("FAIL %s retired: got %0d want %0d", mon_e.nm, retired, mon_e.ret);
      end
      if (mon_e.chk_alu) begin
        n_tests++;
        if ({ALUctr, ALUSrc, ExtOp} !== {mon_e.alu, mon_e.src, mon_e.ext}) begin
          n_fail++;
          $display("FAIL %s alu: got ctr=%0d src=%0d ext=%0d want ctr=%0d src=%0d ext=%0d",
                   mon_e.nm, ALUctr, ALUSrc, ExtOp, mon_e.alu, mon_e.src, mon_e.ext);
        end
      end
    end
  end

  // One clock of stimulus plus its expected response.
  task automatic step(input logic ih, input logic dh, input logic zf,
                      input logic [2:0] st, input logic [14:0] c,
                      input int unsigned ret, input logic ca, input aluop_t a,
                      input logic [1:0] s, input logic x, input string nm);
    exp_t e;
    mif.ihit = ih;
    mif.dhit = dh;
    alu_zf   = zf;
    e.st = st; e.ctl = c; e.ret = ret; e.chk_alu = ca;
    e.alu = a; e.src = s; e.ext = x; e.nm = nm;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input int unsigned ret,
                       input logic [14:0] dec_ctl, input string nm);
    instruction = ins;
    step(1'b1, 1'b0, 1'b0, S_F, C_F_HIT, ret, 1'b0, ALU_ADD, 2'd0, 1'b0, {nm, "_fetch"});
    step(1'b0, 1'b0, 1'b0, S_D, dec_ctl, ret, 1'b0, ALU_ADD, 2'd0, 1'b0, {nm, "_decode"});
  endtask

  // Reset asserted between edges: outputs must already be at reset values.
  task automatic do_reset(input string nm);
    nRST = 1'b0;
    step(1'b0, 1'b0, 1'b0, S_F, C_F_MISS, 0, 1'b0, ALU_ADD, 2'd0, 1'b0, nm);
    nRST = 1'b1;
  endtask

  initial begin
    nRST        = 1'b1;
    instruction = 32'h0;
    alu_zf      = 1'b0;
    mif.ihit    = 1'b0;
    mif.dhit    = 1'b0;
    @(posedge CLK);
    #1;
    do_reset("reset");

    // ADDU: FETCH, DECODE, EXEC, WB
    issue(I_ADDU, 0, C_ZERO, "addu");
    step(0, 0, 0, S_E, C_ZERO, 0, 1, ALU_ADD, 2'd0, 1'b0, "addu_exec");
    step(0, 0, 0, S_W, C_WB_R, 0, 1, ALU_ADD, 2'd0, 1'b0, "addu_wb");

    // LW with dhit after 3 wait cycles
    issue(I_LW, 1, C_ZERO, "lw");
    step(0, 0, 0, S_E, C_ZERO, 1, 1, ALU_ADD, 2'd1, 1'b1, "lw_exec");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, S_M, C_M_LW, 1, 0, ALU_ADD, 2'd0, 1'b0, "lw_mem_wait");
    step(0, 1, 0, S_M, C_M_LW, 1, 0, ALU_ADD, 2'd0, 1'b0, "lw_mem_hit");
    step(0, 0, 0, S_W, C_WB_LW, 1, 1, ALU_ADD, 2'd1, 1'b1, "lw_wb");

    // SW
    issue(I_SW, 2, C_ZERO, "sw");
    step(0, 0, 0, S_E, C_ZERO, 2, 1, ALU_ADD, 2'd1, 1'b1, "sw_exec");
    step(0, 0, 0, S_M, C_M_SW, 2, 0, ALU_ADD, 2'd0, 1'b0, "sw_mem_wait");
    step(0, 1, 0, S_M, C_M_SWHIT, 2, 0, ALU_ADD, 2'd0, 1'b0, "sw_mem_hit");

    // Branches with zero flag set
    issue(I_BEQ, 3, C_ZERO, "beq");
    step(0, 0, 1, S_E, C_BR_T, 3, 1, ALU_SUB, 2'd0, 1'b1, "beq_taken");
    issue(I_BNE, 4, C_ZERO, "bne");
    step(0, 0, 1, S_E, C_BR_N, 4, 1, ALU_SUB, 2'd0, 1'b1, "bne_not_taken");

    // JAL resolves in DECODE
    issue(I_JAL, 5, C_JAL, "jal");

    // Zero-extended and upper immediates
    issue(I_ORI, 6, C_ZERO, "ori");
    step(0, 0, 0, S_E, C_ZERO, 6, 1, ALU_OR, 2'd1, 1'b0, "ori_exec");
    step(0, 0, 0, S_W, C_WB_I, 6, 1, ALU_OR, 2'd1, 1'b0, "ori_wb");
    issue(I_LUI, 7, C_ZERO, "lui");
    step(0, 0, 0, S_E, C_ZERO, 7, 1, ALU_OR, 2'd2, 1'b0, "lui_exec");
    step(0, 0, 0, S_W, C_WB_I, 7, 1, ALU_OR, 2'd2, 1'b0, "lui_wb");

    // ihit on the last allowed FETCH cycle wins over the timeout
    instruction = I_J;
    for (int i = 0; i < TO - 1; i++)
      step(0, 0, 0, S_F, C_F_MISS, 8, 0, ALU_ADD, 2'd0, 1'b0, "fetch_wait");
    step(1, 0, 0, S_F, C_F_HIT, 8, 0, ALU_ADD, 2'd0, 1'b0, "fetch_late_hit");
    step(0, 0, 0, S_D, C_J, 8, 0, ALU_ADD, 2'd0, 1'b0, "j_decode");

    // LW whose dhit never arrives -> ERROR, absorbing
    issue(I_LW, 9, C_ZERO, "lw_to");
    step(0, 0, 0, S_E, C_ZERO, 9, 1, ALU_ADD, 2'd1, 1'b1, "lw_to_exec");
    for (int i = 0; i < TO; i++)
      step(0, 0, 0, S_M, C_M_LW, 9, 0, ALU_ADD, 2'd0, 1'b0, "lw_to_mem");
    step(1, 1, 0, S_X, C_ERR, 9, 0, ALU_ADD, 2'd0, 1'b0, "mem_error");
    step(1, 1, 0, S_X, C_ERR, 9, 0, ALU_ADD, 2'd0, 1'b0, "mem_error_hold");
    do_reset("reset_from_error");

    // HALT opcode: absorbing, retired unchanged
    issue(I_HALT, 0, C_ZERO, "halt");
    step(1, 0, 0, S_H, C_HALT, 0, 0, ALU_ADD, 2'd0, 1'b0, "halt_state");
    step(1, 0, 0, S_H, C_HALT, 0, 0, ALU_ADD, 2'd0, 1'b0, "halt_hold");
    do_reset("reset_from_halt");

    // Unsupported opcode halts
    issue(I_BAD, 0, C_ZERO, "bad_op");
    step(1, 0, 0, S_H, C_HALT, 0, 0, ALU_ADD, 2'd0, 1'b0, "bad_op_halt");
    do_reset("reset_from_bad_op");

    // Reset in the middle of a MEM wait
    issue(I_LW, 0, C_ZERO, "lw_rst");
    step(0, 0, 0, S_E, C_ZERO, 0, 1, ALU_ADD, 2'd1, 1'b1, "lw_rst_exec");
    step(0, 0, 0, S_M, C_M_LW, 0, 0, ALU_ADD, 2'd0, 1'b0, "lw_rst_mem");
    do_reset("reset_mid_mem");

    // Fetch timeout: TO misses then ERROR
    for (int i = 0; i < TO; i++)
      step(0, 0, 0, S_F, C_F_MISS, 0, 0, ALU_ADD, 2'd0, 1'b0, "fetch_to_wait");
    step(0, 0, 0, S_X, C_ERR, 0, 0, ALU_ADD, 2'd0, 1'b0, "fetch_error");

    @(negedge CLK);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_multicycle_control
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum cycles a memory request waits for a hit before the error state; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port nRST  in  1  reset, asynchronous, active-low.
REQ-005 Port instruction  in  32  the current instruction register contents, held stable by the datapath from the IRWr cycle until the next FETCH.
REQ-006 Ports ihit, dhit, alu_zf  in  1 each  instruction-memory hit, data-memory hit, and ALU zero flag.
REQ-007 Ports iREN, dREN, dWEN, IRWr, PCWr, RegWr, ExtOp  out  1 each  memory and datapath enables; ExtOp=1 selects sign extension.
REQ-008 Ports RegDst  out  2 (0 rt, 1 rd, 2 r31); MemToReg  out  2 (0 ALU, 1 memory, 2 PC+4); ALUSrc  out  2 (0 register, 1 extended immediate, 2 immediate<<16).
REQ-009 Port PCSrc  out  3  next-PC select: 0 PC+4, 1 branch target, 2 jump target, 3 rs register.
REQ-010 Port ALUctr  out  aluop_t (cpu_types_pkg)  ALU operation.
REQ-011 Ports halt, mem_err  out  1 each; state  out  3 (debug); retired  out  CNT_W (retired-instruction count).

Function
REQ-012 The block SHALL be an FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
REQ-013 All enables SHALL be decoded combinationally from the state and the instruction; every enable not listed for a state SHALL be 0.
REQ-014 FETCH: iREN=1; on ihit, IRWr=1 -> DECODE; otherwise remain.
REQ-015 DECODE: opcode 0x3F -> HALT; J (0x02): PCWr=1, PCSrc=2 -> FETCH; JAL (0x03): PCWr=1, PCSrc=2, RegWr=1, RegDst=2, MemToReg=2 -> FETCH; unsupported opcode/funct -> HALT; all other instructions -> EXEC.
REQ-016 EXEC, BEQ (0x04) or BNE (0x05): ALUctr=ALU_SUB, PCWr=1, PCSrc=1 if taken (BEQ: alu_zf=1; BNE: alu_zf=0), else PCSrc=0 -> FETCH.
REQ-017 EXEC, JR (R-type, funct 0x08): PCWr=1, PCSrc=3 -> FETCH; LW (0x23) or SW (0x2B): ALUSrc=1, ExtOp=1, ALUctr=ALU_ADD -> MEM; all other instructions -> WB.
REQ-018 MEM: LW drives dREN=1 and SW drives dWEN=1 until dhit; on dhit, LW -> WB; on dhit, SW asserts PCWr=1, PCSrc=0 -> FETCH.
REQ-019 WB: RegWr=1, PCWr=1, PCSrc=0; RegDst=1 for R-type, else 0; MemToReg=1 for LW, else 0 -> FETCH.
REQ-020 EXEC and WB SHALL hold ALU controls stable.
REQ-021 ALUctr mapping: ADDU/ADDIU/LW/SW -> ALU_ADD; SUBU/BEQ/BNE -> ALU_SUB; AND/ANDI -> ALU_AND; OR/ORI/LUI -> ALU_OR; XOR/XORI -> ALU_XOR; NOR -> ALU_NOR; SLT/SLTI -> ALU_SLT; SLTU/SLTIU -> ALU_SLTU; SLL/SRL -> ALU_SLL/ALU_SRL.
REQ-022 Immediate controls: ExtOp=1 for ADDIU/SLTI/SLTIU/LW/SW/BEQ/BNE and 0 for ANDI/ORI/XORI; ALUSrc=2 for LUI.
REQ-023 Wait counter: cleared on entry to FETCH or MEM, incremented each cycle in that state without a hit.
REQ-024 Timeout: when the wait counter equals TIMEOUT_CYC-1 with no hit, the FSM SHALL go to ERROR; a hit in that same cycle SHALL win.
REQ-025 HALT: halt=1, absorbing until reset.
REQ-026 ERROR: halt=1 and mem_err=1, absorbing until reset.
REQ-027 retired SHALL increment by 1 on every transition into FETCH from another state and wrap modulo 2^CNT_W; entry to HALT or ERROR SHALL not increment it.

Reset
REQ-028 nRST low SHALL immediately force state=FETCH, clear the wait counter and retired, and force halt=0 and mem_err=0, including when asserted mid-MEM or in HALT or ERROR.
REQ-029 The first rising CLK edge after nRST deasserts SHALL evaluate FETCH.

Verification
REQ-030 ADDU with ihit=1 -> FETCH, DECODE, EXEC, WB, FETCH; RegWr=1 and RegDst=1 in WB only; retired 0->1.
REQ-031 LW with dhit delayed 3 cycles -> dREN=1 for 4 MEM cycles, then WB with MemToReg=1; SW -> dWEN, then FETCH without RegWr.
REQ-032 BEQ with alu_zf=1 -> PCSrc=1; BNE with alu_zf=1 -> PCSrc=0; JAL -> RegDst=2, MemToReg=2, PCSrc=2 in DECODE.
REQ-033 TIMEOUT_CYC=4, ihit held 0 -> ERROR after 4 FETCH cycles with halt=1 and mem_err=1; ihit arriving on the 4th cycle -> DECODE instead.
REQ-034 Opcode 0x3F -> HALT with halt=1 held and retired unchanged; nRST pulsed low mid-MEM -> FETCH with all outputs at their reset values.
